// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect becomes an exception).
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_EXC   = 2'd0,
        SEL_REDIR = 2'd1,
        SEL_SEQ   = 2'd2,
        SEL_HOLD  = 2'd3
    } pc_sel_t;

    // Mask of the address bits that must be zero for a STEP-aligned PC.
    function automatic logic [63:0] alignment_mask(input int unsigned step);
        return 64'(step - 1);
    endfunction

endpackage

// File: rtl/pc_fetch_cnt.sv
// Wrapping event counter used to count accepted instruction fetches.
module pc_fetch_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: fetch address with valid/ready handshake, prioritised
// exception/redirect/sequential update, halt/resume FSM. Optional macro: PC_ALIGN_CHECK_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080),
    parameter int              STEP      = 4,
    parameter int              CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              exc_valid,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    output logic              redir_taken,
`ifdef PC_ALIGN_CHECK_EN
    output logic              misalign_err,
`endif
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [1:0]        state_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(alignment_mask(STEP));

    pc_state_t         state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic              redir_taken_reg;
    logic              fire;
    pc_sel_t           sel;
    logic [ADDR_W-1:0] target_next;
`ifdef PC_ALIGN_CHECK_EN
    logic              misaligned;
    logic              misalign_err_reg;

    assign misaligned  = |(redir_target & ALIGN_MASK);
    assign target_next = redir_target;
`else
    assign target_next = redir_target & ~ALIGN_MASK;
`endif

    assign req_valid = (state_reg == FETCH) && !stall;
    assign req_addr  = pc_reg;
    assign fire      = req_valid && req_ready;

    // BOOT ignores every event; otherwise exception > redirect > sequential > hold.
    always_comb begin
        sel = SEL_HOLD;
        if (state_reg != BOOT) begin
            if (exc_valid) begin
                sel = SEL_EXC;
            end else if (redir_valid) begin
`ifdef PC_ALIGN_CHECK_EN
                sel = misaligned ? SEL_EXC : SEL_REDIR;
`else
                sel = SEL_REDIR;
`endif
            end else if (fire) begin
                sel = SEL_SEQ;
            end
        end
    end

    always_comb begin
        pc_next = pc_reg;
        case (sel)
            SEL_EXC:   pc_next = EXC_VEC;
            SEL_REDIR: pc_next = target_next;
            SEL_SEQ:   pc_next = pc_reg + ADDR_W'(STEP);
            default:   pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_VEC;
            redir_taken_reg <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_err_reg <= 1'b0;
`endif
        end else begin
            pc_reg          <= pc_next;
            redir_taken_reg <= (sel == SEL_EXC) || (sel == SEL_REDIR);
`ifdef PC_ALIGN_CHECK_EN
            misalign_err_reg <= (state_reg != BOOT) && !exc_valid && redir_valid && misaligned;
`endif
            case (state_reg)
                BOOT:    state_reg <= FETCH;
                FETCH:   if (halt) state_reg <= HALTED;
                HALTED:  if (resume || exc_valid) state_reg <= FETCH;
                default: state_reg <= BOOT;
            endcase
        end
    end

    assign redir_taken = redir_taken_reg;
    assign state_o     = state_reg;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err = misalign_err_reg;
`endif

    pc_fetch_cnt #(
        .CNT_W(CNT_W)
    ) u_fetch_cnt (
        .clk(clk),
        .rst(rst),
        .inc(fire),
        .cnt(fetch_cnt)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (32-bit instance plus an 8-bit wrap instance).
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, halt, resume, redir_valid, exc_valid, req_ready;
    logic [31:0] redir_target;
    logic        req_valid, redir_taken;
    logic [31:0] req_addr, fetch_cnt;
    logic [1:0]  state_o;
    logic        req_valid8, redir_taken8;
    logic [7:0]  req_addr8;
    logic [7:0]  redir_target8;
    logic [31:0] fetch_cnt8;
    logic [1:0]  state8;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err, misalign_err8;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign redir_target8 = redir_target[7:0];

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
        .redir_valid(redir_valid), .redir_target(redir_target), .exc_valid(exc_valid),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .redir_taken(redir_taken),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .fetch_cnt(fetch_cnt), .state_o(state_o)
    );

    pc_gen #(.ADDR_W(8), .RESET_VEC(8'h00), .EXC_VEC(8'h80)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
        .redir_valid(redir_valid), .redir_target(redir_target8), .exc_valid(exc_valid),
        .req_valid(req_valid8), .req_addr(req_addr8), .req_ready(req_ready),
        .redir_taken(redir_taken8),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_err(misalign_err8),
`endif
        .fetch_cnt(fetch_cnt8), .state_o(state8)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; stall = 0; halt = 0; resume = 0; redir_valid = 0; exc_valid = 0;
        req_ready = 1'b1; redir_target = '0;
        tick; tick;
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_valid", 64'(req_valid), 64'd0);
        check("rst_addr", 64'(req_addr), 64'h0);
        check("rst_cnt", 64'(fetch_cnt), 64'd0);
        check("rst_taken", 64'(redir_taken), 64'd0);

        rst = 1'b0;
        #1 check("boot_no_req", 64'(req_valid), 64'd0);
        tick;
        check("fetch_state", 64'(state_o), 64'd1);
        check("seq_addr0", 64'(req_addr), 64'h0);
        tick; check("seq_addr4", 64'(req_addr), 64'h4);
        tick; check("seq_addr8", 64'(req_addr), 64'h8);
        tick; check("cnt_after3", 64'(fetch_cnt), 64'd3);

        tick; check("addr_10", 64'(req_addr), 64'h10);
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("notready_hold", 64'(req_addr), 64'h10);
            check("notready_cnt", 64'(fetch_cnt), 64'd4);
        end
        req_ready = 1'b1;
        tick;
        check("ready_adv", 64'(req_addr), 64'h14);
        check("ready_cnt", 64'(fetch_cnt), 64'd5);

        exc_valid = 1; redir_valid = 1; redir_target = 32'h200;
        tick;
        exc_valid = 0; redir_valid = 0;
        check("exc_wins", 64'(req_addr), 64'h80);
        check("exc_taken", 64'(redir_taken), 64'd1);
        check("exc_cnt", 64'(fetch_cnt), 64'd6);
        tick;
        check("taken_pulse", 64'(redir_taken), 64'd0);
        check("after_exc", 64'(req_addr), 64'h84);
        redir_valid = 1; redir_target = 32'h200;
        tick;
        redir_valid = 0;
        check("redir_200", 64'(req_addr), 64'h200);
        check("redir_taken", 64'(redir_taken), 64'd1);
        check("redir_cnt", 64'(fetch_cnt), 64'd8);

        redir_valid = 1; redir_target = 32'h40;
        tick;
        redir_valid = 0;
        check("redir_40", 64'(req_addr), 64'h40);
        halt = 1; resume = 1;
        tick;
        halt = 0; resume = 0;
        check("halted_state", 64'(state_o), 64'd2);
        check("halt_hs_addr", 64'(req_addr), 64'h44);
        check("halted_valid", 64'(req_valid), 64'd0);
        redir_valid = 1; redir_target = 32'h300;
        tick;
        redir_valid = 0;
        check("halted_redir", 64'(req_addr), 64'h300);
        check("still_halted", 64'(state_o), 64'd2);
        resume = 1;
        tick;
        resume = 0;
        check("resumed", 64'(state_o), 64'd1);
        check("resume_addr", 64'(req_addr), 64'h300);
        check("resume_valid", 64'(req_valid), 64'd1);

        redir_valid = 1; redir_target = 32'h102;
        tick;
        redir_valid = 0;
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_pc", 64'(req_addr), 64'h80);
        check("misalign_err", 64'(misalign_err), 64'd1);
`else
        check("align_pc", 64'(req_addr), 64'h100);
`endif
        check("misalign_taken", 64'(redir_taken), 64'd1);

        stall = 1;
        #1 check("stall_valid", 64'(req_valid), 64'd0);
        redir_valid = 1; redir_target = 32'h500;
        tick;
        check("stall_redir", 64'(req_addr), 64'h500);
        redir_target = 32'h600;
        #1 rst = 1'b1;
        #1;
        check("arst_state", 64'(state_o), 64'd0);
        check("arst_addr", 64'(req_addr), 64'h0);
        check("arst_cnt", 64'(fetch_cnt), 64'd0);
        check("arst_taken", 64'(redir_taken), 64'd0);
        tick;
        rst = 0; stall = 0; redir_valid = 0;
        tick;
        check("w8_fetch", 64'(state8), 64'd1);
        redir_valid = 1; redir_target = 32'hFC;
        tick;
        redir_valid = 0;
        check("w8_fc", 64'(req_addr8), 64'hFC);
        tick;
        check("w8_wrap", 64'(req_addr8), 64'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage; successor to the plain single-register PC.
- Generates the instruction-fetch address with a valid/ready handshake to instruction memory.
- Handles exception redirects, branch/jump redirects, stall and halt/resume, with a fixed priority.
- Counts accepted fetches for performance monitoring.

Parameters:
ADDR_W, 32, width of PC and all address ports
RESET_VEC, 32'h0000_0000, PC value loaded on reset
EXC_VEC, 32'h0000_0080, PC value loaded on exception
STEP, 4, sequential increment in bytes; power of two, at least 1
CNT_W, 32, width of the fetch counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  downstream cannot take a new instruction; hold PC
halt  input  1  level; enter HALTED
resume  input  1  pulse; leave HALTED
redir_valid  input  1  branch/jump taken this cycle
redir_target  input  ADDR_W  branch/jump target
exc_valid  input  1  exception/trap this cycle
req_valid  output  1  fetch request valid
req_addr  output  ADDR_W  fetch address, equal to current PC
req_ready  input  1  imem accepts the request
redir_taken  output  1  one-cycle pulse: PC was redirected
fetch_cnt  output  CNT_W  number of accepted fetches, wraps
state_o  output  2  current FSM state, for debug

Behaviour:
- Reset (asynchronous, any time, including mid-handshake): PC=RESET_VEC, state=BOOT, req_valid=0, redir_taken=0, fetch_cnt=0.
- States:
  - BOOT = 0: one cycle with no request, then FETCH.
  - FETCH = 1.
  - HALTED = 2.
- Request signals:
  - req_valid = (state==FETCH) && !stall. Combinational from state and stall.
  - req_addr = PC.
- Next-PC priority, evaluated every cycle in every state except BOOT:
  1. exc_valid: PC <= EXC_VEC.
  2. Else redir_valid: PC <= redir_target.
  3. Else if req_valid && req_ready: PC <= PC+STEP, modulo 2^ADDR_W (wraps at the top of the address space).
  4. Else hold.
- Redirect effect:
  - A redirect or exception withdraws any un-accepted request. The new address appears next cycle.
  - An accepted request in the same cycle still counts in fetch_cnt.
  - redir_taken pulses the cycle after case 1 or case 2 applies.
- fetch_cnt increments by 1 on every cycle where req_valid && req_ready. Wraps to 0 at 2^CNT_W.
- FSM transitions:
  - BOOT -> FETCH unconditionally.
  - FETCH -> HALTED when halt=1, next cycle. A handshake in the same cycle still completes.
  - HALTED -> FETCH when resume=1 or exc_valid=1.
  - halt and resume both high in FETCH: halt wins.
  - In HALTED, redir_valid updates PC but the state stays HALTED.
- BOOT cycle: redir_valid and exc_valid are ignored.
- Stall only gates req_valid. It does not block redirects.
- redir_target low bits below log2(STEP) are handled by the optional feature.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined: adds output misalign_err (1 bit, reset 0).
  - A redirect whose target has nonzero bits below log2(STEP) is treated as an exception: PC <= EXC_VEC.
  - misalign_err and redir_taken both pulse the next cycle.
- Undefined: no misalign_err port; the low log2(STEP) bits of redir_target are forced to zero before loading.

Decomposition:
- Package pc_pkg holds:
  - the state encoding: BOOT, FETCH, HALTED, 2 bits;
  - the priority-select encoding: SEL_EXC, SEL_REDIR, SEL_SEQ, SEL_HOLD;
  - a function alignment_mask(STEP).
- One sub-module: pc_fetch_cnt, a parametrised CNT_W wrapping counter with inc and async rst.

Test Plan:
- Reset then idle with req_ready=1 (defaults): cycle 0 after rst release has req_valid=0; then req_addr = 0x0, 0x4, 0x8; fetch_cnt=3 after 3 accepts.
- req_ready low for 3 cycles at PC=0x10: req_addr holds 0x10, fetch_cnt unchanged; ready high -> 0x14.
- Same cycle exc_valid=1 and redir_valid=1 with target 0x200: next PC=0x80, redir_taken=1 for one cycle; next cycle with no events -> redir_valid target 0x200 loads 0x200.
- Halt at PC=0x40 with a handshake completing the same cycle: HALTED with PC=0x44, req_valid=0. Redirect to 0x300 while halted: PC=0x300, still HALTED. resume -> req_addr=0x300.
- rst pulsed while stall=1 and a redirect is in flight: outputs return to the reset values immediately; PC=RESET_VEC. With ADDR_W=8: PC 0xFC advances to 0x00.
- With PC_ALIGN_CHECK_EN, redirect to 0x102: PC=0x80, misalign_err=1. Without the macro: PC=0x100, no error.
